// File: rtl/memory_instruction_queue_pkg.sv
// Shared types and sizing for the memory instruction queue.
// Entry layout: is_load at MSB, then target, then per-lane fields.
package memory_instruction_queue_pkg;

    localparam int MEMORY_ADDRESS_BITS   = 15;
    localparam int SUPERSCALAR_LOG_WIDTH = 2;
    localparam int SUPERSCALAR_WIDTH     = 1 << SUPERSCALAR_LOG_WIDTH;
    localparam int LOG_DEPTH             = 3;
    localparam int DEPTH                 = 1 << LOG_DEPTH;
    localparam int STALL_MARGIN          = 2;
    localparam int LANE_W  = MEMORY_ADDRESS_BITS * 3 + 15;
    localparam int ENTRY_W = LANE_W * SUPERSCALAR_WIDTH + 2;

    typedef logic [SUPERSCALAR_LOG_WIDTH-1:0] copy_count_t;
    typedef logic [LOG_DEPTH-1:0]             ptr_t;
    typedef logic [LOG_DEPTH:0]               occ_t;
    typedef logic [ENTRY_W-1:0]               entry_t;
    typedef logic [MEMORY_ADDRESS_BITS-1:0]   maddr_t;

    typedef struct packed {
        maddr_t addr;
        maddr_t stridex;
        maddr_t stridey;
    } src_t;

    typedef struct packed {
        maddr_t daddr;
        maddr_t dstridex;
        maddr_t dstridey;
    } dst_t;

    // Loads walk the DRAM side, stores the scratchpad side; one view per lane.
    typedef union packed {
        src_t s;
        dst_t d;
    } xfer_t;

    typedef struct packed {
        logic [6:0] height;
        logic [5:0] width;
        logic       zero_flag;
        logic       skip_flag;
        xfer_t      x;
    } lane_t;

    typedef struct packed {
        logic                             is_load;
        logic                             target;
        lane_t [SUPERSCALAR_WIDTH-1:0]    lane;
    } queued_memory_instruction;

    function automatic logic stall_for(occ_t occ);
        return (occ_t'(DEPTH) - occ) < occ_t'(STALL_MARGIN);
    endfunction

endpackage

// File: rtl/memory_instruction_queue_if.sv
// Producer/consumer bundle of the memory instruction queue.
// slave: the queue itself; master: the surrounding producer and consumer.
interface memory_instruction_queue_if;
    import memory_instruction_queue_pkg::*;

    logic        in_we;
    entry_t      in_instr;
    copy_count_t in_copy_count;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    entry_t      out_instr;
    copy_count_t out_copy_count;
    occ_t        occupancy;
    logic        overflow;

    modport slave (
        input  in_we, in_instr, in_copy_count, out_ready,
        output stall, out_valid, out_instr, out_copy_count,
        output occupancy, overflow
    );

    modport master (
        output in_we, in_instr, in_copy_count, out_ready,
        input  stall, out_valid, out_instr, out_copy_count,
        input  occupancy, overflow
    );

endinterface

// File: rtl/memory_instruction_queue.sv
// FIFO of memory instructions between control_unit and the issue stage.
// Define MEMORY_INSTRUCTION_QUEUE_BYPASS_EN for a same-cycle path when empty.
module memory_instruction_queue
    import memory_instruction_queue_pkg::*;
(
    input logic                       clk,
    input logic                       reset,
    memory_instruction_queue_if.slave q
);

    queued_memory_instruction mem_q [DEPTH];
    copy_count_t              cc_q  [DEPTH];

    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    occ_t occ_q, occ_d;
    logic stall_q, stall_d;
    logic ovf_q, ovf_d;

    logic full, empty, push, pop, bypass;

    assign full  = (occ_q == occ_t'(DEPTH));
    assign empty = (occ_q == '0);

`ifdef MEMORY_INSTRUCTION_QUEUE_BYPASS_EN
    assign bypass = empty && q.in_we && q.out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry is consumed in flight and never occupies a slot.
    assign push = q.in_we && !full && !bypass;
    assign pop  = !empty && q.out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q + occ_t'(push) - occ_t'(pop);
        ovf_d    = ovf_q | (q.in_we && full);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        stall_d  = stall_for(occ_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= queued_memory_instruction'(q.in_instr);
            cc_q[wr_ptr_q]  <= q.in_copy_count;
        end
    end

    assign q.out_valid      = !empty || bypass;
    assign q.out_instr      = bypass ? q.in_instr : entry_t'(mem_q[rd_ptr_q]);
    assign q.out_copy_count = bypass ? q.in_copy_count : cc_q[rd_ptr_q];
    assign q.occupancy      = occ_q;
    assign q.stall          = stall_q;
    assign q.overflow       = ovf_q;

endmodule

// File: tb/tb_memory_instruction_queue.sv
// Directed bench for memory_instruction_queue.
// Inputs change 1 time unit after posedge; outputs are checked there too.
module tb_memory_instruction_queue;
    import memory_instruction_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    memory_instruction_queue_if q_if ();

    memory_instruction_queue dut (
        .clk   (clk),
        .reset (rst_n),
        .q     (q_if)
    );

    function automatic entry_t e(int k);
        logic [255:0] t;
        for (int w = 0; w < 8; w++)
            t[w*32 +: 32] = (32'(k + 1) * 32'h9E37_79B1) ^ (32'(w) << 20);
        return t[ENTRY_W-1:0];
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic we, int k, logic rdy);
        q_if.in_we         = we;
        q_if.in_instr      = e(k);
        q_if.in_copy_count = copy_count_t'(k);
        q_if.out_ready     = rdy;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        drive(1'b0, 0, 1'b0);

        // 1: reset
        #12;
        chk("rst_valid", 256'(q_if.out_valid), 256'(0));
        chk("rst_occ", 256'(q_if.occupancy), 256'(0));
        chk("rst_stall", 256'(q_if.stall), 256'(0));
        chk("rst_ovf", 256'(q_if.overflow), 256'(0));
        rst_n = 1'b1;
        tick();
        chk("post_rst_occ", 256'(q_if.occupancy), 256'(0));

        // 2: single write with consumer ready, copy_count 3
        drive(1'b1, 3, 1'b1);
        #1;
`ifdef MEMORY_INSTRUCTION_QUEUE_BYPASS_EN
        chk("byp_valid_c0", 256'(q_if.out_valid), 256'(1));
        chk("byp_instr_c0", 256'(q_if.out_instr), 256'(e(3)));
        chk("byp_cc_c0", 256'(q_if.out_copy_count), 256'(3));
        tick();
        q_if.in_we = 1'b0;
        #1;
        chk("byp_occ_c1", 256'(q_if.occupancy), 256'(0));
        chk("byp_valid_c1", 256'(q_if.out_valid), 256'(0));
`else
        chk("w1_valid_c0", 256'(q_if.out_valid), 256'(0));
        tick();
        q_if.in_we = 1'b0;
        #1;
        chk("w1_valid_c1", 256'(q_if.out_valid), 256'(1));
        chk("w1_instr_c1", 256'(q_if.out_instr), 256'(e(3)));
        chk("w1_cc_c1", 256'(q_if.out_copy_count), 256'(3));
        chk("w1_occ_c1", 256'(q_if.occupancy), 256'(1));
`endif
        tick();
        chk("w1_occ_c2", 256'(q_if.occupancy), 256'(0));
        chk("w1_valid_c2", 256'(q_if.out_valid), 256'(0));

        // 3: fill, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 10 + i, 1'b0);
            tick();
            if (i == 5) chk("stall_after6", 256'(q_if.stall), 256'(0));
            if (i == 6) chk("stall_after7", 256'(q_if.stall), 256'(1));
        end
        chk("full_occ", 256'(q_if.occupancy), 256'(8));
        chk("full_ovf0", 256'(q_if.overflow), 256'(0));
        drive(1'b1, 99, 1'b0);
        tick();
        chk("ovf_set", 256'(q_if.overflow), 256'(1));
        chk("ovf_occ", 256'(q_if.occupancy), 256'(8));
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("drain_instr%0d", i), 256'(q_if.out_instr),
                256'(e(10 + i)));
            chk($sformatf("drain_cc%0d", i), 256'(q_if.out_copy_count),
                256'(copy_count_t'(10 + i)));
            tick();
        end
        chk("drain_occ", 256'(q_if.occupancy), 256'(0));
        chk("drain_stall", 256'(q_if.stall), 256'(0));
        chk("ovf_sticky", 256'(q_if.overflow), 256'(1));

        // 4: write while full with a same-cycle pop
        pulse_reset();
        chk("rst2_ovf", 256'(q_if.overflow), 256'(0));
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 20 + i, 1'b0);
            tick();
        end
        drive(1'b1, 77, 1'b1);
        tick();
        chk("fullpop_occ", 256'(q_if.occupancy), 256'(7));
        chk("fullpop_ovf", 256'(q_if.overflow), 256'(1));
        drive(1'b0, 0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            #1;
            chk($sformatf("fp_instr%0d", i), 256'(q_if.out_instr),
                256'(e(20 + i)));
            tick();
        end
        chk("fp_empty", 256'(q_if.out_valid), 256'(0));

        // 5: steady push+pop from occupancy 3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 30 + i, 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 33 + i, 1'b1);
            #1;
            chk($sformatf("pp_head%0d", i), 256'(q_if.out_instr),
                256'(e(30 + i)));
            tick();
            chk($sformatf("pp_occ%0d", i), 256'(q_if.occupancy), 256'(3));
        end
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("pp_tail%0d", i), 256'(q_if.out_instr),
                256'(e(50 + i)));
            tick();
        end
        chk("pp_empty", 256'(q_if.occupancy), 256'(0));

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 60 + i, 1'b0);
            tick();
        end
        drive(1'b0, 0, 1'b0);
        chk("pre_async_occ", 256'(q_if.occupancy), 256'(5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_occ", 256'(q_if.occupancy), 256'(0));
        chk("async_valid", 256'(q_if.out_valid), 256'(0));
        #1;
        rst_n = 1'b1;
        tick();
        chk("after_async_occ", 256'(q_if.occupancy), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
